// File: rtl/hm_time_core.sv
// Hour/minute BCD time-keeping core: synchronises and edge-detects the
// hour/minute increment lines and returns one-cycle minute/day carry pulses.
module hm_time_core #(
    parameter bit HOUR_24 = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc_h,
    input  logic       inc_m,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       pm,
    output logic       m_carry,
    output logic       h_carry
);

    localparam logic [1:0] HOUR_TENS_RST = HOUR_24 ? 2'd0 : 2'd1;
    localparam logic [3:0] HOUR_ONES_RST = HOUR_24 ? 4'd0 : 4'd2;

    logic [1:0] inc_vec;
    logic [1:0] edge_det;
    logic       edge_m;
    logic       edge_h;

    assign inc_vec = {inc_h, inc_m};

    // Bit 0 is the minute line, bit 1 the hour line.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic s3_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                    s3_reg <= 1'b0;
                end else begin
                    s1_reg <= inc_vec[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                end
            end

            assign edge_det[gi] = s2_reg & ~s3_reg;
        end
    endgenerate

    assign edge_m = edge_det[0];
    assign edge_h = edge_det[1];

    logic [2:0] min_tens_reg, min_tens_next;
    logic [3:0] min_ones_reg, min_ones_next;
    logic [1:0] hour_tens_reg, hour_tens_next;
    logic [3:0] hour_ones_reg, hour_ones_next;
    logic       pm_reg, pm_next;
    logic       m_carry_reg, m_carry_next;
    logic       h_carry_reg, h_carry_next;

    always_comb begin
        min_tens_next = min_tens_reg;
        min_ones_next = min_ones_reg;
        m_carry_next  = 1'b0;
        if (edge_m) begin
            if (min_tens_reg > 3'd5 || min_ones_reg > 4'd9) begin
                min_tens_next = 3'd0;
                min_ones_next = 4'd0;
            end else if (min_ones_reg == 4'd9) begin
                min_ones_next = 4'd0;
                if (min_tens_reg == 3'd5) begin
                    min_tens_next = 3'd0;
                    m_carry_next  = 1'b1;
                end else begin
                    min_tens_next = min_tens_reg + 3'd1;
                end
            end else begin
                min_ones_next = min_ones_reg + 4'd1;
            end
        end
    end

    generate
        if (HOUR_24) begin : g_h24
            logic h_legal;
            assign h_legal = (hour_tens_reg < 2'd2 && hour_ones_reg <= 4'd9) ||
                             (hour_tens_reg == 2'd2 && hour_ones_reg <= 4'd3);

            always_comb begin
                hour_tens_next = hour_tens_reg;
                hour_ones_next = hour_ones_reg;
                pm_next        = 1'b0;
                h_carry_next   = 1'b0;
                if (edge_h) begin
                    if (!h_legal || (hour_tens_reg == 2'd2 && hour_ones_reg == 4'd3)) begin
                        hour_tens_next = 2'd0;
                        hour_ones_next = 4'd0;
                        h_carry_next   = h_legal;
                    end else if (hour_ones_reg == 4'd9) begin
                        hour_ones_next = 4'd0;
                        hour_tens_next = hour_tens_reg + 2'd1;
                    end else begin
                        hour_ones_next = hour_ones_reg + 4'd1;
                    end
                end
            end
        end else begin : g_h12
            logic h_legal;
            assign h_legal = (hour_tens_reg == 2'd0 && hour_ones_reg >= 4'd1 && hour_ones_reg <= 4'd9) ||
                             (hour_tens_reg == 2'd1 && hour_ones_reg <= 4'd2);

            always_comb begin
                hour_tens_next = hour_tens_reg;
                hour_ones_next = hour_ones_reg;
                pm_next        = pm_reg;
                h_carry_next   = 1'b0;
                if (edge_h) begin
                    if (!h_legal) begin
                        hour_tens_next = 2'd1;
                        hour_ones_next = 4'd2;
                        pm_next        = 1'b0;
                    end else if (hour_tens_reg == 2'd1 && hour_ones_reg == 4'd2) begin
                        hour_tens_next = 2'd0;
                        hour_ones_next = 4'd1;
                    end else if (hour_tens_reg == 2'd1 && hour_ones_reg == 4'd1) begin
                        // 11 -> 12 flips AM/PM; leaving PM is the day wrap.
                        hour_ones_next = 4'd2;
                        pm_next        = ~pm_reg;
                        h_carry_next   = pm_reg;
                    end else if (hour_ones_reg == 4'd9) begin
                        hour_tens_next = 2'd1;
                        hour_ones_next = 4'd0;
                    end else begin
                        hour_ones_next = hour_ones_reg + 4'd1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            min_tens_reg  <= 3'd0;
            min_ones_reg  <= 4'd0;
            hour_tens_reg <= HOUR_TENS_RST;
            hour_ones_reg <= HOUR_ONES_RST;
            pm_reg        <= 1'b0;
            m_carry_reg   <= 1'b0;
            h_carry_reg   <= 1'b0;
        end else begin
            min_tens_reg  <= min_tens_next;
            min_ones_reg  <= min_ones_next;
            hour_tens_reg <= hour_tens_next;
            hour_ones_reg <= hour_ones_next;
            pm_reg        <= pm_next;
            m_carry_reg   <= m_carry_next;
            h_carry_reg   <= h_carry_next;
        end
    end

    assign min_tens  = min_tens_reg;
    assign min_ones  = min_ones_reg;
    assign hour_tens = hour_tens_reg;
    assign hour_ones = hour_ones_reg;
    assign pm        = pm_reg;
    assign m_carry   = m_carry_reg;
    assign h_carry   = h_carry_reg;

endmodule

// File: tb/tb_hm_time_core.sv
// Directed bench for hm_time_core: one 24 h and one 12 h instance share the
// same stimulus; table rows walk minutes and hours through their wraps.
module tb_hm_time_core;

    logic clk;
    logic reset;
    logic inc_h;
    logic inc_m;

    logic [2:0] mt24, mt12;
    logic [3:0] mo24, mo12;
    logic [1:0] ht24, ht12;
    logic [3:0] ho24, ho12;
    logic       pm24, pm12;
    logic       mc24, mc12;
    logic       hc24, hc12;

    hm_time_core #(.HOUR_24(1'b1)) dut24 (
        .clk(clk), .reset(reset), .inc_h(inc_h), .inc_m(inc_m),
        .min_tens(mt24), .min_ones(mo24), .hour_tens(ht24), .hour_ones(ho24),
        .pm(pm24), .m_carry(mc24), .h_carry(hc24)
    );

    hm_time_core #(.HOUR_24(1'b0)) dut12 (
        .clk(clk), .reset(reset), .inc_h(inc_h), .inc_m(inc_m),
        .min_tens(mt12), .min_ones(mo12), .hour_tens(ht12), .hour_ones(ho12),
        .pm(pm12), .m_carry(mc12), .h_carry(hc12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int mc24_cnt, mc12_cnt, hc24_cnt, hc12_cnt;
    logic cap_mc24, cap_mc12, cap_hc24, cap_hc12;

    typedef struct {
        int n_m;
        int n_h;
        int mt;
        int mo;
        int h24t;
        int h24o;
        int h12t;
        int h12o;
        int pm12;
        int mc;
        int hc24;
        int hc12;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One clock, sampled 1 time unit after the rising edge; tallies carry pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        mc24_cnt += int'(mc24);
        mc12_cnt += int'(mc12);
        hc24_cnt += int'(hc24);
        hc12_cnt += int'(hc12);
    endtask

    task automatic clear_counts();
        mc24_cnt = 0;
        mc12_cnt = 0;
        hc24_cnt = 0;
        hc12_cnt = 0;
    endtask

    // Two cycles high, two low; the update lands on the third sample.
    task automatic step(input logic h, input logic m);
        inc_h = h;
        inc_m = m;
        tick();
        tick();
        inc_h = 1'b0;
        inc_m = 1'b0;
        tick();
        cap_mc24 = mc24;
        cap_mc12 = mc12;
        cap_hc24 = hc24;
        cap_hc12 = hc12;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        inc_h = 1'b0;
        inc_m = 1'b0;
        clear_counts();

        //            n_m n_h mt mo h24t h24o h12t h12o pm mc hc24 hc12
        vecs[0]  = '{  9,  0, 0, 9,  0,   0,   1,   2,  0, 0,  0,   0};
        vecs[1]  = '{  1,  0, 1, 0,  0,   0,   1,   2,  0, 0,  0,   0};
        vecs[2]  = '{ 49,  0, 5, 9,  0,   0,   1,   2,  0, 0,  0,   0};
        vecs[3]  = '{  1,  0, 0, 0,  0,   0,   1,   2,  0, 1,  0,   0};
        vecs[4]  = '{  0,  1, 0, 0,  0,   1,   0,   1,  0, 0,  0,   0};
        vecs[5]  = '{  0,  8, 0, 0,  0,   9,   0,   9,  0, 0,  0,   0};
        vecs[6]  = '{  0,  1, 0, 0,  1,   0,   1,   0,  0, 0,  0,   0};
        vecs[7]  = '{  0,  1, 0, 0,  1,   1,   1,   1,  0, 0,  0,   0};
        vecs[8]  = '{  0,  1, 0, 0,  1,   2,   1,   2,  1, 0,  0,   0};
        vecs[9]  = '{  0,  7, 0, 0,  1,   9,   0,   7,  1, 0,  0,   0};
        vecs[10] = '{  0,  1, 0, 0,  2,   0,   0,   8,  1, 0,  0,   0};
        vecs[11] = '{  0,  3, 0, 0,  2,   3,   1,   1,  1, 0,  0,   0};
        vecs[12] = '{  0,  1, 0, 0,  0,   0,   1,   2,  0, 0,  1,   1};

        // Reset state
        tick();
        do_reset();
        $display("reset: min %0d%0d h24 %0d%0d h12 %0d%0d pm %0d", mt24, mo24, ht24, ho24, ht12, ho12, pm12);
        chk("rst_mt24", mt24, 0);
        chk("rst_mo24", mo24, 0);
        chk("rst_ht24", ht24, 0);
        chk("rst_ho24", ho24, 0);
        chk("rst_pm24", pm24, 0);
        chk("rst_mc24", mc24, 0);
        chk("rst_hc24", hc24, 0);
        chk("rst_ht12", ht12, 1);
        chk("rst_ho12", ho12, 2);
        chk("rst_pm12", pm12, 0);

        // Latency and level-hold: inc_m first sampled at edge N, visible after N+2
        inc_m = 1'b1;
        tick();
        chk("lat_n", mo24, 0);
        tick();
        chk("lat_n1", mo24, 0);
        tick();
        chk("lat_n2", mo24, 1);
        repeat (17) tick();
        chk("hold_mo24", mo24, 1);
        chk("hold_mo12", mo12, 1);
        inc_m = 1'b0;
        tick();
        tick();
        $display("latency: min_ones %0d after held inc_m", mo24);

        do_reset();
        tick();

        foreach (vecs[i]) begin
            clear_counts();
            repeat (vecs[i].n_m) step(1'b0, 1'b1);
            repeat (vecs[i].n_h) step(1'b1, 1'b0);
            $display("row %0d: +%0dm +%0dh -> min %0d%0d h24 %0d%0d h12 %0d%0d pm %0d mc %0d hc %0d/%0d",
                     i, vecs[i].n_m, vecs[i].n_h, mt24, mo24, ht24, ho24, ht12, ho12, pm12,
                     mc24_cnt, hc24_cnt, hc12_cnt);
            chk($sformatf("row%0d_mt24", i), mt24, vecs[i].mt);
            chk($sformatf("row%0d_mo24", i), mo24, vecs[i].mo);
            chk($sformatf("row%0d_mt12", i), mt12, vecs[i].mt);
            chk($sformatf("row%0d_mo12", i), mo12, vecs[i].mo);
            chk($sformatf("row%0d_ht24", i), ht24, vecs[i].h24t);
            chk($sformatf("row%0d_ho24", i), ho24, vecs[i].h24o);
            chk($sformatf("row%0d_ht12", i), ht12, vecs[i].h12t);
            chk($sformatf("row%0d_ho12", i), ho12, vecs[i].h12o);
            chk($sformatf("row%0d_pm12", i), pm12, vecs[i].pm12);
            chk($sformatf("row%0d_pm24", i), pm24, 0);
            chk($sformatf("row%0d_mc24n", i), mc24_cnt, vecs[i].mc);
            chk($sformatf("row%0d_mc12n", i), mc12_cnt, vecs[i].mc);
            chk($sformatf("row%0d_hc24n", i), hc24_cnt, vecs[i].hc24);
            chk($sformatf("row%0d_hc12n", i), hc12_cnt, vecs[i].hc12);
        end

        // Simultaneous hour and minute edges with minutes at 59
        repeat (59) step(1'b0, 1'b1);
        chk("pre_sim_mt", mt24, 5);
        chk("pre_sim_mo", mo24, 9);
        clear_counts();
        step(1'b1, 1'b1);
        $display("simul: min %0d%0d h24 %0d%0d h12 %0d%0d pm %0d mc %0d", mt24, mo24, ht24, ho24, ht12, ho12, pm12, mc24_cnt);
        chk("sim_cap_mc24", cap_mc24, 1);
        chk("sim_cap_mc12", cap_mc12, 1);
        chk("sim_cap_hc24", cap_hc24, 0);
        chk("sim_cap_hc12", cap_hc12, 0);
        chk("sim_mt", mt24, 0);
        chk("sim_mo", mo24, 0);
        chk("sim_ho24", ho24, 1);
        chk("sim_ht24", ht24, 0);
        chk("sim_ho12", ho12, 1);
        chk("sim_ht12", ht12, 0);
        chk("sim_pm12", pm12, 0);
        chk("sim_mc_n", mc24_cnt, 1);
        chk("sim_hc_n", hc24_cnt + hc12_cnt, 0);

        // Reset during a held inc_m
        inc_m = 1'b1;
        repeat (3) tick();
        chk("prerst_mo", mo24, 1);
        do_reset();
        chk("midrst_mo", mo24, 0);
        chk("midrst_ho24", ho24, 0);
        chk("midrst_ho12", ho12, 2);
        chk("midrst_ht12", ht12, 1);
        tick();
        chk("rel_r", mo24, 0);
        tick();
        chk("rel_r1", mo24, 0);
        tick();
        chk("rel_r2", mo24, 1);
        repeat (8) tick();
        chk("rel_hold", mo24, 1);
        inc_m = 1'b0;
        tick();
        tick();
        $display("reset-hold: min_ones %0d after release", mo24);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hm_time_core.md
# hm_time_core

Hour/minute time-keeping core for the digital clock. It sits downstream of the hour/minute routing mux and consumes that mux's two outputs. Each rising edge on the hour or minute increment line advances a BCD counter. A one-cycle minute-carry pulse is returned upstream, where the mux feeds it back to the hour line in run mode. Both increment lines may come from a push-button, so the block synchronises them and detects their edges internally.

## Interface
- HOUR_24, default 1: 1 = hours count 00..23; 0 = 12-hour mode, hours count 01..12 with a PM flag.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- inc_h  in  1  hour increment request; level input from the mux hour output; asynchronous to clk.
- inc_m  in  1  minute increment request; level input from the mux minute output; asynchronous to clk.
- min_tens  out  3  minutes tens digit, BCD 0..5.
- min_ones  out  4  minutes ones digit, BCD 0..9.
- hour_tens  out  2  hours tens digit, BCD 0..2.
- hour_ones  out  4  hours ones digit, BCD 0..9.
- pm  out  1  PM flag; held 0 when HOUR_24=1.
- m_carry  out  1  one-cycle pulse on each minute wrap from 59 to 00.
- h_carry  out  1  one-cycle pulse on each day wrap: 23→00 (24 h) or 11 PM→12 AM (12 h).

## Operation
- Input path, per input: sync flops s1 and s2, then history flop s3. The edge signal is s2 & ~s3.
- Only a rising edge counts. A level held high produces exactly one increment. Falling edges are ignored.
- Minute counter, on each minute edge:
  - Ones digit increments.
  - Ones 9→0 increments tens.
  - Tens 5 with ones 9 wraps to 00 and asserts m_carry for one cycle on the same clock edge.
- Minutes never carry into hours internally. Hour advance happens only via inc_h, because the upstream mux routes m_carry back to inc_h in run mode.
- Hour counter, 24 h mode:
  - BCD increment, with ones 9→0 and tens +1.
  - 23 wraps to 00 with an h_carry pulse.
- Hour counter, 12 h mode:
  - Sequence is 12, 01, 02, …, 11, 12.
  - 11→12 toggles pm.
  - 11 with pm=1 → 12 also asserts h_carry.
  - The 12→01 step does not toggle pm.
- Simultaneous hour and minute edges are processed independently in the same cycle. A minute wrap in that cycle does not cause an extra hour increment inside this block.
- Digits are always legal BCD within range. No illegal state is reachable; an unreachable state is recovered to the reset value on the next increment.

## Timing
- Reset values:
  - All digit outputs 0, m_carry 0, h_carry 0, pm 0, all sync/history flops 0.
  - 12 h mode: hour_tens=1, hour_ones=2, pm=0 (12 AM).
- Reset mid-operation: reset wins over any pending edge that cycle. Sync history is cleared, so an input held high across reset release produces one increment about 3 cycles after release.
- Latency: an input first sampled high at clock edge N sets s1 at N and s2 at N+1. The counter updates at edge N+2, so the new value is visible after N+2.
- m_carry and h_carry are registered and asserted for exactly one cycle. They are coincident with the counter update that wrapped.
- Minimum input pulse width: 2 clk periods high and 2 low to guarantee detection. Shorter pulses may be missed.
- Increment throughput: at most one increment per counter every 2 cycles, limited by the input edge spacing.

## Test plan
- Reset check: assert reset for 2 cycles with HOUR_24=1. All outputs must be 0. With HOUR_24=0, hours must read 12 and pm=0.
- Single increment and latency: raise inc_m and hold it for 20 cycles. min_ones goes 0→1 exactly 3 clock edges after inc_m is first sampled high. No further increment occurs while inc_m is held.
- Minute wrap: apply 60 inc_m edges from 00. Check sequence 09→10 and 59→00. m_carry must be high for exactly one cycle at the 59→00 update. Hours stay 00.
- Hour wrap, 24 h: apply 24 inc_h edges from 00. Check 09→10, 19→20 and 23→00. h_carry pulses once at 23→00.
- Hour wrap, 12 h: apply 24 inc_h edges from 12 AM. Check 12→01 with pm unchanged, and 11→12 with pm toggled. h_carry pulses once, at 11 PM→12 AM.
- Simultaneous events and reset: with minutes at 59, drive inc_h and inc_m edges in the same cycle. The result must be hours +1, minutes 00, and one m_carry pulse. Then assert reset during a held inc_m. Outputs clear, and exactly one increment follows about 3 cycles after reset release.
